// File: rtl/event_sync.sv
// Multi-channel event synchroniser: synchronises async sources into clk, detects edges per channel
// mode, and queues events in saturating pending counters drained by a valid/ready handshake.
module event_sync #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 3
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [CHANNELS-1:0]       i_async_in,
  input  logic [2*CHANNELS-1:0]     i_edge_mode,
  input  logic [CHANNELS-1:0]       i_clear,
  output logic [CHANNELS-1:0]       o_evt_pulse,
  output logic [CHANNELS-1:0]       o_evt_valid,
  input  logic [CHANNELS-1:0]       i_evt_ready,
  output logic [CHANNELS*CNT_W-1:0] o_evt_count,
  output logic [CHANNELS-1:0]       o_overflow
);

  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

  localparam logic [1:0] MODE_ANY  = 2'd0;
  localparam logic [1:0] MODE_RISE = 2'd1;
  localparam logic [1:0] MODE_FALL = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
  logic [CHANNELS-1:0]                  r_hist;
  logic [ARM_W-1:0]                     r_arm_cnt;
  logic [CHANNELS-1:0][CNT_W-1:0]       r_count;
  logic [CHANNELS-1:0]                  r_valid;
  logic [CHANNELS-1:0]                  r_ovf;
  logic [CHANNELS-1:0]                  r_pulse;

  logic                                 w_armed;
  logic [CHANNELS-1:0]                  w_sync_out;
  logic [CHANNELS-1:0]                  w_rise;
  logic [CHANNELS-1:0]                  w_fall;
  logic [CHANNELS-1:0]                  w_event;
  logic [CHANNELS-1:0]                  w_consume;
  logic [CHANNELS-1:0][CNT_W-1:0]       w_count_d;
  logic [CHANNELS-1:0]                  w_ovf_d;

  // Only the last stage is observed; earlier stages feed nothing but the next flop.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= i_async_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  // Detection stays masked until the chain and history hold real post-reset samples.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  assign w_armed    = (r_arm_cnt == ARM_W'(ARM_CYCLES));
  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_sync_out & ~r_hist;
  assign w_fall     = ~w_sync_out & r_hist;

  always_comb begin
    w_event = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (i_edge_mode[2*i +: 2])
        MODE_ANY:  w_event[i] = w_rise[i] | w_fall[i];
        MODE_RISE: w_event[i] = w_rise[i];
        MODE_FALL: w_event[i] = w_fall[i];
        default:   w_event[i] = 1'b0;
      endcase
      w_event[i] = w_event[i] & w_armed;
    end
  end

  assign w_consume = r_valid & i_evt_ready;

  always_comb begin
    w_count_d = r_count;
    w_ovf_d   = r_ovf;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i_clear[i]) begin
        w_count_d[i] = '0;
        w_ovf_d[i]   = 1'b0;
      end else if (w_event[i] && w_consume[i]) begin
        w_count_d[i] = r_count[i];
      end else if (w_event[i]) begin
        if (r_count[i] == CNT_MAX) begin
          w_ovf_d[i] = 1'b1;
        end else begin
          w_count_d[i] = r_count[i] + 1'b1;
        end
      end else if (w_consume[i]) begin
        // r_valid guarantees a non-zero count here.
        w_count_d[i] = r_count[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
      r_valid <= '0;
      r_ovf   <= '0;
      r_pulse <= '0;
    end else begin
      r_count <= w_count_d;
      r_ovf   <= w_ovf_d;
      r_pulse <= w_event;
      for (int i = 0; i < CHANNELS; i++) begin
        r_valid[i] <= (w_count_d[i] != '0);
      end
    end
  end

  assign o_evt_pulse = r_pulse;
  assign o_evt_valid = r_valid;
  assign o_evt_count = r_count;
  assign o_overflow  = r_ovf;

endmodule
